stopwatch_control: RTL and testbench

Sequencing controller for the stopwatch counter chain and the digit display. It takes debounced start/stop, lap and clear buttons plus the 1 Hz tick strobe. It gates the tick into the seconds counters, issues a synchronous clear to them, and freezes the displayed digits while a lap is held. It sits between the one-second clock / reset debouncer and the Counter / Display_Digits instances in au_top.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_control_if.sv | 34 +++
 rtl/stopwatch_control_rising_edge_detect.sv | 24 ++
 rtl/stopwatch_control.sv | 111 +++++++++++
 tb/tb_stopwatch_control.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencing controller.
//   - State encodings (visible on the state output / LEDs).
//   - Default digit geometry used by the interface and the controller.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_LAP     = 2'd3;

    localparam int DEFAULT_DIGIT_WIDTH      = 4;
    localparam int DEFAULT_NUMBER_OF_DIGITS = 2;

    typedef enum logic [1:0] {
        STATE_IDLE    = ST_IDLE,
        STATE_RUNNING = ST_RUNNING,
        STATE_PAUSED  = ST_PAUSED,
        STATE_LAP     = ST_LAP
    } state_t;

endpackage

// File: rtl/stopwatch_control_if.sv
// Bundle of the signals between the button/tick sources, the controller and
// the counter/display chain.
//   master : drives tick, buttons and live digits; observes controller outputs
//   slave  : the controller itself
interface stopwatch_control_if
    import stopwatch_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS = DEFAULT_NUMBER_OF_DIGITS,
    parameter int DIGIT_WIDTH      = DEFAULT_DIGIT_WIDTH
);
    localparam int W = NUMBER_OF_DIGITS * DIGIT_WIDTH;

    logic         tick;
    logic         btn_start_stop;
    logic         btn_lap;
    logic         btn_clear;
    logic [W-1:0] digits_in;
    logic         count_en;
    logic         counter_clear;
    logic [W-1:0] digits_out;
    logic         running;
    logic         frozen;
    logic [1:0]   state;

    modport master (
        output tick, btn_start_stop, btn_lap, btn_clear, digits_in,
        input  count_en, counter_clear, digits_out, running, frozen, state
    );

    modport slave (
        input  tick, btn_start_stop, btn_lap, btn_clear, digits_in,
        output count_en, counter_clear, digits_out, running, frozen, state
    );
endinterface

// File: rtl/stopwatch_control_rising_edge_detect.sv
// Single-cycle press detector for a debounced button level.
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : debounced level
//   pulse      : high for the cycle in which in rises
// The history register resets to 1 so a button held through reset must be
// released before it can register a press.
module rising_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);
    logic in_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg <= 1'b1;
        end else begin
            in_reg <= in;
        end
    end

    assign pulse = in & ~in_reg;
endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch sequencing controller: gates the 1 Hz tick into the counter
// chain, issues a synchronous counter clear and freezes the displayed digits
// while a lap is held.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of stopwatch_control_if (tick, buttons, live
//                digits in; count_en, counter_clear, digits_out, running,
//                frozen, state out)
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS = DEFAULT_NUMBER_OF_DIGITS,
    parameter int DIGIT_WIDTH      = DEFAULT_DIGIT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_control_if.slave bus
);
    localparam int W = NUMBER_OF_DIGITS * DIGIT_WIDTH;

    // Button order within the vectors: 0 = start_stop, 1 = lap, 2 = clear.
    logic [2:0] btn_level;
    logic [2:0] btn_press;

    assign btn_level = {bus.btn_clear, bus.btn_lap, bus.btn_start_stop};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_press
            rising_edge_detect u_edge (
                .clk   (clk),
                .rst_n (rst_n),
                .in    (btn_level[gi]),
                .pulse (btn_press[gi])
            );
        end
    endgenerate

    logic press_start_stop;
    logic press_lap;
    logic press_clear;

    assign press_start_stop = btn_press[0];
    assign press_lap        = btn_press[1];
    assign press_clear      = btn_press[2];

    state_t       state_reg;
    logic         counter_clear_reg;
    logic [W-1:0] lap_reg;

    // Presses are checked in clear > start_stop > lap order within each
    // state; a press the current state ignores does not mask a lower one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= STATE_IDLE;
            counter_clear_reg <= 1'b0;
            lap_reg           <= '0;
        end else begin
            counter_clear_reg <= 1'b0;
            case (state_reg)
                STATE_IDLE: begin
                    if (press_clear) begin
                        counter_clear_reg <= 1'b1;
                    end else if (press_start_stop) begin
                        state_reg <= STATE_RUNNING;
                    end
                end
                STATE_RUNNING: begin
                    if (press_start_stop) begin
                        state_reg <= STATE_PAUSED;
                    end else if (press_lap) begin
                        state_reg <= STATE_LAP;
                        // Captured before any same-cycle tick lands in the
                        // counters, so the pre-increment value is held.
                        lap_reg   <= bus.digits_in;
                    end
                end
                STATE_LAP: begin
                    if (press_start_stop) begin
                        state_reg <= STATE_PAUSED;
                    end else if (press_lap) begin
                        state_reg <= STATE_RUNNING;
                    end
                end
                STATE_PAUSED: begin
                    if (press_clear) begin
                        state_reg         <= STATE_IDLE;
                        counter_clear_reg <= 1'b1;
                    end else if (press_start_stop) begin
                        state_reg <= STATE_RUNNING;
                    end
                end
                default: begin
                    state_reg <= STATE_IDLE;
                end
            endcase
        end
    end

    // The counters advance whenever the current (pre-edge) state is a run
    // state, so a tick coinciding with a stop press still counts and one
    // coinciding with a start press does not.
    logic run_state;
    assign run_state = (state_reg == STATE_RUNNING) || (state_reg == STATE_LAP);

    assign bus.count_en      = bus.tick & run_state;
    assign bus.counter_clear = counter_clear_reg;
    assign bus.running       = run_state;
    assign bus.frozen        = (state_reg == STATE_LAP);
    assign bus.state         = state_reg;
    assign bus.digits_out    = (state_reg == STATE_LAP) ? lap_reg : bus.digits_in;
endmodule

// File: tb/tb_stopwatch_control.sv
module tb_stopwatch_control;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    stopwatch_control_if #(.NUMBER_OF_DIGITS(2), .DIGIT_WIDTH(4)) bus ();

    stopwatch_control #(.NUMBER_OF_DIGITS(2), .DIGIT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic ce;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // One press transaction: drive buttons/tick for one cycle starting at a
    // falling edge, report count_en seen during that cycle, release at the
    // next falling edge (state already updated by then).
    task automatic press(input logic ss, input logic lp, input logic cl,
                         input logic tk, output logic ce_seen);
        @(negedge clk);
        bus.btn_start_stop = ss;
        bus.btn_lap        = lp;
        bus.btn_clear      = cl;
        bus.tick           = tk;
        #1 ce_seen = bus.count_en;
        @(negedge clk);
        bus.btn_start_stop = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.tick           = 1'b0;
        #1;
        $display("press ss=%0b lap=%0b clr=%0b tick=%0b -> state=%0d count_en=%0b clear=%0b",
                 ss, lp, cl, tk, bus.state, ce_seen, bus.counter_clear);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        bus.btn_start_stop = 1'b1;
        bus.btn_lap = 1'b0;
        bus.btn_clear = 1'b0;
        bus.tick = 1'b1;
        bus.digits_in = 8'h00;
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        checks++;
        if (bus.count_en !== 1'b0 || bus.counter_clear !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: count_en=%0b clear=%0b expected 0/0", bus.count_en, bus.counter_clear);
        end
        checks++;
        if (bus.running !== 1'b0 || bus.frozen !== 1'b0) begin
            errors++; $display("FAIL reset_flags: running=%0b frozen=%0b expected 0/0", bus.running, bus.frozen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.tick = (i % 3 == 0);
            #1;
            if (bus.state !== ST_IDLE || bus.count_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL held_through_reset: %0d bad cycles expected 0", bad); end
        @(negedge clk);
        bus.tick = 1'b0;
        bus.btn_start_stop = 1'b0;
        press(1, 0, 0, 0, ce);
        checks++;
        if (bus.state !== ST_RUNNING) begin errors++; $display("FAIL first_start: state=%0d expected 1", bus.state); end
    endtask

    task automatic test_run_ticks();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.tick = (i % 8 == 0);
            exp_q.push_back((i % 8 == 0) ? 8'd1 : 8'd0);
            #1;
            if (bus.count_en === 1'b1) pulses++;
            exp_v = exp_q.pop_front();
            checks++;
            if ({7'd0, bus.count_en} !== exp_v) begin
                errors++; $display("FAIL run_count_en[%0d]: got %0b expected %0d", i, bus.count_en, exp_v);
            end
        end
        bus.tick = 1'b0;
        checks++;
        if (pulses != 5) begin errors++; $display("FAIL run_pulses: got %0d expected 5", pulses); end
        press(1, 0, 0, 0, ce);
        checks++;
        if (bus.state !== ST_PAUSED) begin errors++; $display("FAIL stop: state=%0d expected 2", bus.state); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.tick = (i % 8 == 0);
            exp_q.push_back(8'd0);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if ({7'd0, bus.count_en} !== exp_v) begin
                errors++; $display("FAIL paused_count_en[%0d]: got %0b expected %0d", i, bus.count_en, exp_v);
            end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_lap();
        logic [7:0] seq [5];
        seq = '{8'h37, 8'h38, 8'h39, 8'h40, 8'h41};
        press(1, 0, 0, 0, ce);
        checks++;
        if (bus.state !== ST_RUNNING) begin errors++; $display("FAIL resume: state=%0d expected 1", bus.state); end
        bus.digits_in = 8'h37;
        press(0, 1, 0, 0, ce);
        checks++;
        if (bus.state !== ST_LAP || bus.frozen !== 1'b1 || bus.running !== 1'b1) begin
            errors++; $display("FAIL lap_enter: state=%0d frozen=%0b running=%0b expected 3/1/1", bus.state, bus.frozen, bus.running);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.digits_in = seq[i];
            exp_q.push_back(8'h37);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.digits_out !== exp_v) begin
                errors++; $display("FAIL lap_hold[%0d]: got %h expected %h", i, bus.digits_out, exp_v);
            end
        end
        press(0, 1, 0, 0, ce);
        checks++;
        if (bus.state !== ST_RUNNING || bus.frozen !== 1'b0 || bus.digits_out !== 8'h41) begin
            errors++; $display("FAIL lap_release: state=%0d frozen=%0b digits=%h expected 1/0/41", bus.state, bus.frozen, bus.digits_out);
        end
        @(negedge clk);
        bus.digits_in = 8'h42;
        #1;
        checks++;
        if (bus.digits_out !== 8'h42) begin errors++; $display("FAIL live_follow: got %h expected 42", bus.digits_out); end
    endtask

    task automatic test_clear();
        press(0, 0, 1, 0, ce);
        checks++;
        if (bus.counter_clear !== 1'b0 || bus.state !== ST_RUNNING) begin
            errors++; $display("FAIL clear_in_running: clear=%0b state=%0d expected 0/1", bus.counter_clear, bus.state);
        end
        press(1, 0, 0, 0, ce);
        press(0, 0, 1, 0, ce);
        checks++;
        if (bus.counter_clear !== 1'b1 || bus.state !== ST_IDLE) begin
            errors++; $display("FAIL clear_pulse: clear=%0b state=%0d expected 1/0", bus.counter_clear, bus.state);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.counter_clear !== 1'b0) begin errors++; $display("FAIL clear_width: got %0b expected 0", bus.counter_clear); end
        press(0, 0, 1, 0, ce);
        checks++;
        if (bus.counter_clear !== 1'b1 || bus.state !== ST_IDLE) begin
            errors++; $display("FAIL clear_in_idle: clear=%0b state=%0d expected 1/0", bus.counter_clear, bus.state);
        end
    endtask

    task automatic test_same_cycle();
        press(1, 0, 0, 1, ce);
        checks++;
        if (ce !== 1'b0 || bus.state !== ST_RUNNING) begin
            errors++; $display("FAIL start_with_tick: count_en=%0b state=%0d expected 0/1", ce, bus.state);
        end
        press(1, 1, 0, 0, ce);
        checks++;
        if (bus.state !== ST_PAUSED || bus.frozen !== 1'b0) begin
            errors++; $display("FAIL ss_plus_lap: state=%0d frozen=%0b expected 2/0", bus.state, bus.frozen);
        end
        press(1, 0, 1, 0, ce);
        checks++;
        if (bus.state !== ST_IDLE || bus.counter_clear !== 1'b1) begin
            errors++; $display("FAIL clear_plus_ss: state=%0d clear=%0b expected 0/1", bus.state, bus.counter_clear);
        end
        press(1, 0, 0, 0, ce);
        press(1, 0, 0, 1, ce);
        checks++;
        if (ce !== 1'b1 || bus.state !== ST_PAUSED) begin
            errors++; $display("FAIL stop_with_tick: count_en=%0b state=%0d expected 1/2", ce, bus.state);
        end
        press(1, 0, 0, 1, ce);
        checks++;
        if (ce !== 1'b0 || bus.state !== ST_RUNNING) begin
            errors++; $display("FAIL resume_with_tick: count_en=%0b state=%0d expected 0/1", ce, bus.state);
        end
        bus.digits_in = 8'h19;
        press(0, 1, 0, 1, ce);
        bus.digits_in = 8'h20;
        #1;
        checks++;
        if (ce !== 1'b1 || bus.state !== ST_LAP || bus.digits_out !== 8'h19) begin
            errors++; $display("FAIL lap_with_tick: count_en=%0b state=%0d digits=%h expected 1/3/19", ce, bus.state, bus.digits_out);
        end
    endtask

    task automatic test_reset_in_lap();
        @(negedge clk);
        bus.tick = 1'b1;
        bus.digits_in = 8'h50;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== ST_IDLE || bus.frozen !== 1'b0 || bus.running !== 1'b0) begin
            errors++; $display("FAIL async_reset_state: state=%0d frozen=%0b running=%0b expected 0/0/0", bus.state, bus.frozen, bus.running);
        end
        checks++;
        if (bus.count_en !== 1'b0 || bus.digits_out !== 8'h50) begin
            errors++; $display("FAIL async_reset_outputs: count_en=%0b digits=%h expected 0/50", bus.count_en, bus.digits_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.tick = 1'b0;
        press(1, 0, 0, 0, ce);
        bus.digits_in = 8'h07;
        press(0, 1, 0, 0, ce);
        checks++;
        if (bus.state !== ST_LAP || bus.digits_out !== 8'h07) begin
            errors++; $display("FAIL post_reset_lap: state=%0d digits=%h expected 3/07", bus.state, bus.digits_out);
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_lap();
        test_clear();
        test_same_cycle();
        test_reset_in_lap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
